pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage core. Collects hazard and wait conditions from ID, EX, MEM and the instruction memory, and drives the per-stage `stop`, `kill` and flush controls. Owns the redirect path into the fetch stage: it registers the EX-resolved target and holds `if_kill`/`if_jump_pc` for a programmable number of cycles. It also runs a stall watchdog.

---
 rtl/pipe_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: per-stage stop/kill/flush, fetch redirect and stall watchdog.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int WDOG_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_redirect,
    input  logic [31:0] ex_redirect_pc,
    input  logic        id_load_use,
    input  logic        imem_wait,
    input  logic        dmem_wait,
    output logic        if_stop,
    output logic        if_kill,
    output logic [31:0] if_jump_pc,
    output logic        id_stop,
    output logic        id_flush,
    output logic        ex_stop,
    output logic        mem_stop,
    output logic [1:0]  ctrl_state,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt,
`endif
    output logic        wdog_err
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_t;

    localparam logic [1:0]        FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX   = '1;
    localparam logic [WDOG_W-1:0] WDOG_ONE   = {{(WDOG_W-1){1'b0}}, 1'b1};

    state_t            state;
    state_t            state_next;
    logic [1:0]        flush_cnt;
    logic [1:0]        flush_cnt_next;
    logic              pc_capture;
    logic [WDOG_W-1:0] wdog_cnt;
    logic              stall_cycle;

    logic if_stop_c;
    logic if_kill_c;
    logic id_stop_c;
    logic id_flush_c;
    logic ex_stop_c;
    logic mem_stop_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_RUN;
            flush_cnt  <= '0;
            if_jump_pc <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
            if (pc_capture) begin
                if_jump_pc <= ex_redirect_pc;
            end
        end
    end

    // MEM stalls beat redirects, which beat ID/fetch stalls.
    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        pc_capture     = 1'b0;
        if_stop_c      = 1'b0;
        if_kill_c      = 1'b0;
        id_stop_c      = 1'b0;
        id_flush_c     = 1'b0;
        ex_stop_c      = 1'b0;
        mem_stop_c     = 1'b0;
        case (state)
            ST_RUN: begin
                if (dmem_wait) begin
                    if_stop_c  = 1'b1;
                    id_stop_c  = 1'b1;
                    ex_stop_c  = 1'b1;
                    mem_stop_c = 1'b1;
                    state_next = ST_MEMWAIT;
                end else if (ex_redirect) begin
                    id_flush_c     = 1'b1;
                    pc_capture     = 1'b1;
                    flush_cnt_next = FLUSH_LOAD;
                    state_next     = ST_FLUSH;
                end else if (id_load_use || imem_wait) begin
                    if_stop_c  = 1'b1;
                    id_stop_c  = 1'b1;
                    id_flush_c = 1'b1;
                end
            end
            ST_FLUSH: begin
                if_kill_c  = 1'b1;
                id_flush_c = 1'b1;
                ex_stop_c  = dmem_wait;
                mem_stop_c = dmem_wait;
                if (flush_cnt == 2'd0) begin
                    state_next = ST_RUN;
                end else begin
                    flush_cnt_next = flush_cnt - 2'd1;
                end
            end
            ST_MEMWAIT: begin
                if (dmem_wait) begin
                    if_stop_c  = 1'b1;
                    id_stop_c  = 1'b1;
                    ex_stop_c  = 1'b1;
                    mem_stop_c = 1'b1;
                end else begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // RUN-state controls follow the inputs, so they must be masked during reset.
    assign if_stop    = reset & if_stop_c;
    assign if_kill    = reset & if_kill_c;
    assign id_stop    = reset & id_stop_c;
    assign id_flush   = reset & id_flush_c;
    assign ex_stop    = reset & ex_stop_c;
    assign mem_stop   = reset & mem_stop_c;
    assign ctrl_state = state;

    assign stall_cycle = if_stop & ~if_kill;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
        end else if (stall_cycle) begin
            if (wdog_cnt != WDOG_MAX) begin
                wdog_cnt <= wdog_cnt + WDOG_ONE;
            end
            if (wdog_cnt >= WDOG_MAX - WDOG_ONE) begin
                wdog_err <= 1'b1;
            end
        end else begin
            wdog_cnt <= '0;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (if_stop) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (pc_capture) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: two instances (FLUSH_CYCLES 1 and 3, WDOG_W 4)
// driven in lockstep and compared every cycle against a rule-level reference model.
module tb_pipe_ctrl;

    localparam int WDOG_LIMIT = 15;

    logic        clk;
    logic        reset;
    logic        ex_redirect;
    logic [31:0] ex_redirect_pc;
    logic        id_load_use;
    logic        imem_wait;
    logic        dmem_wait;

    logic [1:0]  if_stop_o;
    logic [1:0]  if_kill_o;
    logic [1:0]  id_stop_o;
    logic [1:0]  id_flush_o;
    logic [1:0]  ex_stop_o;
    logic [1:0]  mem_stop_o;
    logic [1:0]  wdog_err_o;
    logic [31:0] if_jump_pc_o [2];
    logic [1:0]  ctrl_state_o [2];
    logic [31:0] perf_stall_o [2];
    logic [31:0] perf_flush_o [2];

    int tests_run;
    int tests_failed;
    int flush_len [2];

    typedef struct {
        int          kill_left;
        bit          in_memwait;
        logic [31:0] pc;
        int          stall_run;
        bit          err;
        logic [31:0] stall_total;
        logic [31:0] flush_total;
    } model_t;

    typedef struct {
        logic        if_stop;
        logic        if_kill;
        logic        id_stop;
        logic        id_flush;
        logic        ex_stop;
        logic        mem_stop;
        logic [1:0]  state;
        logic [31:0] pc;
        logic        err;
        logic [31:0] stall_total;
        logic [31:0] flush_total;
    } exp_t;

    model_t mdl [2];

    pipe_ctrl #(.FLUSH_CYCLES(1), .WDOG_W(4)) dut_f1 (
        .clk            (clk),
        .reset          (reset),
        .ex_redirect    (ex_redirect),
        .ex_redirect_pc (ex_redirect_pc),
        .id_load_use    (id_load_use),
        .imem_wait      (imem_wait),
        .dmem_wait      (dmem_wait),
        .if_stop        (if_stop_o[0]),
        .if_kill        (if_kill_o[0]),
        .if_jump_pc     (if_jump_pc_o[0]),
        .id_stop        (id_stop_o[0]),
        .id_flush       (id_flush_o[0]),
        .ex_stop        (ex_stop_o[0]),
        .mem_stop       (mem_stop_o[0]),
        .ctrl_state     (ctrl_state_o[0]),
`ifdef PIPE_CTRL_PERF_EN
        .perf_stall_cnt (perf_stall_o[0]),
        .perf_flush_cnt (perf_flush_o[0]),
`endif
        .wdog_err       (wdog_err_o[0])
    );

    pipe_ctrl #(.FLUSH_CYCLES(3), .WDOG_W(4)) dut_f3 (
        .clk            (clk),
        .reset          (reset),
        .ex_redirect    (ex_redirect),
        .ex_redirect_pc (ex_redirect_pc),
        .id_load_use    (id_load_use),
        .imem_wait      (imem_wait),
        .dmem_wait      (dmem_wait),
        .if_stop        (if_stop_o[1]),
        .if_kill        (if_kill_o[1]),
        .if_jump_pc     (if_jump_pc_o[1]),
        .id_stop        (id_stop_o[1]),
        .id_flush       (id_flush_o[1]),
        .ex_stop        (ex_stop_o[1]),
        .mem_stop       (mem_stop_o[1]),
        .ctrl_state     (ctrl_state_o[1]),
`ifdef PIPE_CTRL_PERF_EN
        .perf_stall_cnt (perf_stall_o[1]),
        .perf_flush_cnt (perf_flush_o[1]),
`endif
        .wdog_err       (wdog_err_o[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic model_t model_init();
        model_t m;
        m.kill_left   = 0;
        m.in_memwait  = 1'b0;
        m.pc          = '0;
        m.stall_run   = 0;
        m.err         = 1'b0;
        m.stall_total = '0;
        m.flush_total = '0;
        return m;
    endfunction

    // One cycle of the behavioural rules: expected outputs now, model state after the edge.
    function automatic void model_step(input model_t s_in, input int fl, input bit rst_n,
                                       input bit redir, input logic [31:0] tpc, input bit lu,
                                       input bit iw, input bit dw, output exp_t e,
                                       output model_t ns);
        model_t s;
        s = rst_n ? s_in : model_init();
        e.if_stop  = 1'b0;
        e.if_kill  = 1'b0;
        e.id_stop  = 1'b0;
        e.id_flush = 1'b0;
        e.ex_stop  = 1'b0;
        e.mem_stop = 1'b0;
        e.state    = (s.kill_left > 0) ? 2'd1 : (s.in_memwait ? 2'd2 : 2'd0);
        e.pc          = s.pc;
        e.err         = s.err;
        e.stall_total = s.stall_total;
        e.flush_total = s.flush_total;
        ns = s;
        if (!rst_n) return;
        if (s.kill_left > 0) begin
            e.if_kill  = 1'b1;
            e.id_flush = 1'b1;
            e.ex_stop  = dw;
            e.mem_stop = dw;
            ns.kill_left = s.kill_left - 1;
        end else if (s.in_memwait) begin
            if (dw) begin
                e.if_stop = 1'b1; e.id_stop = 1'b1; e.ex_stop = 1'b1; e.mem_stop = 1'b1;
            end else begin
                ns.in_memwait = 1'b0;
            end
        end else if (dw) begin
            e.if_stop = 1'b1; e.id_stop = 1'b1; e.ex_stop = 1'b1; e.mem_stop = 1'b1;
            ns.in_memwait = 1'b1;
        end else if (redir) begin
            e.id_flush     = 1'b1;
            ns.pc          = tpc;
            ns.kill_left   = fl;
            ns.flush_total = s.flush_total + 32'd1;
        end else if (lu || iw) begin
            e.if_stop = 1'b1; e.id_stop = 1'b1; e.id_flush = 1'b1;
        end
        if (e.if_stop && !e.if_kill) begin
            ns.stall_run = (s.stall_run + 1 > WDOG_LIMIT) ? WDOG_LIMIT : s.stall_run + 1;
            if (ns.stall_run == WDOG_LIMIT) ns.err = 1'b1;
        end else begin
            ns.stall_run = 0;
        end
        if (e.if_stop) ns.stall_total = s.stall_total + 32'd1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then check both instances against the model.
    task automatic applyStimulus(input bit rst_n, input bit redir, input logic [31:0] tpc,
                                 input bit lu, input bit iw, input bit dw);
        exp_t   e;
        model_t ns;
        string  sfx;
        @(negedge clk);
        reset          = rst_n;
        ex_redirect    = redir;
        ex_redirect_pc = tpc;
        id_load_use    = lu;
        imem_wait      = iw;
        dmem_wait      = dw;
        #1;
        for (int d = 0; d < 2; d++) begin
            model_step(mdl[d], flush_len[d], rst_n, redir, tpc, lu, iw, dw, e, ns);
            sfx = $sformatf("[F%0d t=%0t]", flush_len[d], $time);
            checkOutput({"if_stop", sfx},    {31'd0, if_stop_o[d]},    {31'd0, e.if_stop});
            checkOutput({"if_kill", sfx},    {31'd0, if_kill_o[d]},    {31'd0, e.if_kill});
            checkOutput({"id_stop", sfx},    {31'd0, id_stop_o[d]},    {31'd0, e.id_stop});
            checkOutput({"id_flush", sfx},   {31'd0, id_flush_o[d]},   {31'd0, e.id_flush});
            checkOutput({"ex_stop", sfx},    {31'd0, ex_stop_o[d]},    {31'd0, e.ex_stop});
            checkOutput({"mem_stop", sfx},   {31'd0, mem_stop_o[d]},   {31'd0, e.mem_stop});
            checkOutput({"ctrl_state", sfx}, {30'd0, ctrl_state_o[d]}, {30'd0, e.state});
            checkOutput({"if_jump_pc", sfx}, if_jump_pc_o[d],          e.pc);
            checkOutput({"wdog_err", sfx},   {31'd0, wdog_err_o[d]},   {31'd0, e.err});
`ifdef PIPE_CTRL_PERF_EN
            checkOutput({"perf_stall", sfx}, perf_stall_o[d], e.stall_total);
            checkOutput({"perf_flush", sfx}, perf_flush_o[d], e.flush_total);
`endif
            mdl[d] = ns;
        end
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        flush_len[0]   = 1;
        flush_len[1]   = 3;
        mdl[0]         = model_init();
        mdl[1]         = model_init();
        reset          = 1'b0;
        ex_redirect    = 1'b0;
        ex_redirect_pc = '0;
        id_load_use    = 1'b0;
        imem_wait      = 1'b0;
        dmem_wait      = 1'b0;

        // Reset held for three cycles, then idle.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Single redirect to 0x120.
        applyStimulus(1'b1, 1'b1, 32'h0000_0120, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Redirect to 0x40 followed by a redirect that arrives during FLUSH.
        applyStimulus(1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0099, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // MEM stall for four cycles with a redirect held alongside it.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // One-cycle load-use bubble.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Fresh reset, then 15 consecutive imem stalls trip the 4-bit watchdog.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("wdog_sticky_f1", {31'd0, wdog_err_o[0]}, 32'd1);
        checkOutput("wdog_sticky_f3", {31'd0, wdog_err_o[1]}, 32'd1);

        // Reset clears the sticky flag.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Randomised traffic with occasional reset pulses.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 99) != 0,
                          $urandom_range(0, 4) == 0,
                          $urandom(),
                          $urandom_range(0, 5) == 0,
                          $urandom_range(0, 4) == 0,
                          $urandom_range(0, 5) == 0);
        end

        // Reset during FLUSH drops the kill at once.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("kill_abort_f3", {31'd0, if_kill_o[1]}, 32'd0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
